// File: rtl/branch_resolve_unit.sv
// Purpose: in-flight branch record buffer; compares predictions with execute outcomes, drives recovery and predictor training.
// Latency: enq_ready/enq_tag are combinational; every other output is registered one cycle after the resolution.
// Backpressure: enq_ready drops when full, when a mispredict resolves this cycle, and during the registered mispredict pulse.
// Ports: CLK/reset (sync, active-high); enq_* record handshake with enq_tag; res_* execute outcomes;
//        mispredict/restore_ghr recovery; update_pht/btb/ras strobes with their data outputs; ex_* registered resolve info.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int PHT_ADDRESS = 9,
    parameter int GHR_SIZE    = 9,
    parameter int DEPTH       = 8,
    localparam int TAGW       = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic                   enq_pred_taken,
    input  logic [XLEN-1:0]        enq_pred_target,
    input  logic [PHT_ADDRESS-1:0] enq_pht_index,
    input  logic [GHR_SIZE-1:0]    enq_ghr_snap,
    output logic [TAGW-1:0]        enq_tag,
    input  logic                   res_valid,
    input  logic [TAGW-1:0]        res_tag,
    input  logic [XLEN-1:0]        res_pc,
    input  logic                   res_taken,
    input  logic [XLEN-1:0]        res_target,
    input  logic                   res_is_branch,
    input  logic                   res_is_ret,
    input  logic                   res_is_call,
    output logic                   mispredict,
    output logic                   restore_ghr,
    output logic                   actual_taken,
    output logic [XLEN-1:0]        actual_target_address,
    output logic [GHR_SIZE-1:0]    ghr_snap,
    output logic [PHT_ADDRESS-1:0] rb_pht_index,
    output logic                   update_pht,
    output logic                   update_btb,
    output logic                   update_ras,
    output logic [XLEN-1:0]        ex_pc,
    output logic                   ex_is_branch,
    output logic                   ex_is_ret,
    output logic [XLEN-1:0]        actual_return_address
);

    localparam logic [TAGW:0] FULL = (TAGW+1)'(DEPTH);

    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       resolved_q;
    logic                   pred_taken_q  [DEPTH];
    logic [XLEN-1:0]        pred_target_q [DEPTH];
    logic [PHT_ADDRESS-1:0] pht_index_q   [DEPTH];
    logic [GHR_SIZE-1:0]    ghr_q         [DEPTH];

    logic [TAGW-1:0] head;
    logic [TAGW-1:0] tail;
    logic [TAGW:0]   count;

    logic            hit;
    logic            mp_now;
    logic            pop;
    logic            enq_fire;
    logic [TAGW-1:0] tag_off;
    logic [DEPTH-1:0] flush_mask;
    logic [TAGW-1:0] slot_off;

    always_comb begin
        hit        = res_valid && valid_q[res_tag] && !resolved_q[res_tag];
        mp_now     = hit && ((res_taken != pred_taken_q[res_tag]) ||
                             (res_taken && (res_target != pred_target_q[res_tag])));
        // A head entry resolved in this same cycle only pops on the next one.
        pop        = valid_q[head] && resolved_q[head];
        enq_ready  = !reset && (count < FULL) && !mp_now && !mispredict;
        enq_fire   = enq_valid && enq_ready;
        enq_tag    = tail;
        // Age is distance from head; anything older-than-or-equal to the
        // mispredicted branch survives a flush.
        tag_off    = res_tag - head;
        flush_mask = '0;
        slot_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off      = TAGW'(i) - head;
            flush_mask[i] = mp_now && (slot_off > tag_off);
        end
    end

    // Record payload needs no reset: valid_q gates every use of it.
    always_ff @(posedge CLK) begin
        if (enq_fire) begin
            pred_taken_q[tail]  <= enq_pred_taken;
            pred_target_q[tail] <= enq_pred_target;
            pht_index_q[tail]   <= enq_pht_index;
            ghr_q[tail]         <= enq_ghr_snap;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            valid_q    <= '0;
            resolved_q <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            valid_q <= valid_q & ~flush_mask;
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + TAGW'(1);
            end
            if (hit) begin
                resolved_q[res_tag] <= 1'b1;
            end
            if (enq_fire) begin
                valid_q[tail]    <= 1'b1;
                resolved_q[tail] <= 1'b0;
            end
            if (mp_now) begin
                tail  <= res_tag + TAGW'(1);
                count <= {1'b0, tag_off} + (TAGW+1)'(1) - (TAGW+1)'(pop);
            end else begin
                if (enq_fire) begin
                    tail <= tail + TAGW'(1);
                end
                count <= count + (TAGW+1)'(enq_fire) - (TAGW+1)'(pop);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            mispredict            <= 1'b0;
            restore_ghr           <= 1'b0;
            actual_taken          <= 1'b0;
            actual_target_address <= '0;
            ghr_snap              <= '0;
            rb_pht_index          <= '0;
            update_pht            <= 1'b0;
            update_btb            <= 1'b0;
            update_ras            <= 1'b0;
            ex_pc                 <= '0;
            ex_is_branch          <= 1'b0;
            ex_is_ret             <= 1'b0;
            actual_return_address <= '0;
        end else begin
            mispredict  <= mp_now;
            restore_ghr <= mp_now;
            update_pht  <= hit && res_is_branch;
            update_btb  <= hit && res_taken;
            update_ras  <= hit && res_is_call;
            if (hit) begin
                actual_taken          <= res_taken;
                actual_target_address <= res_taken ? res_target : res_pc + XLEN'(4);
                ghr_snap              <= ghr_q[res_tag];
                rb_pht_index          <= pht_index_q[res_tag];
                ex_pc                 <= res_pc;
                ex_is_branch          <= res_is_branch;
                ex_is_ret             <= res_is_ret;
                if (res_is_call) begin
                    actual_return_address <= res_pc + XLEN'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int DEPTH = 8;

    logic        CLK = 1'b0;
    logic        reset;
    logic        enq_valid;
    logic        enq_ready;
    logic        enq_pred_taken;
    logic [31:0] enq_pred_target;
    logic [8:0]  enq_pht_index;
    logic [8:0]  enq_ghr_snap;
    logic [2:0]  enq_tag;
    logic        res_valid;
    logic [2:0]  res_tag;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_is_branch;
    logic        res_is_ret;
    logic        res_is_call;
    logic        mispredict;
    logic        restore_ghr;
    logic        actual_taken;
    logic [31:0] actual_target_address;
    logic [8:0]  ghr_snap;
    logic [8:0]  rb_pht_index;
    logic        update_pht;
    logic        update_btb;
    logic        update_ras;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_ret;
    logic [31:0] actual_return_address;

    branch_resolve_unit dut (
        .CLK(CLK), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target),
        .enq_pht_index(enq_pht_index), .enq_ghr_snap(enq_ghr_snap), .enq_tag(enq_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target),
        .res_is_branch(res_is_branch), .res_is_ret(res_is_ret), .res_is_call(res_is_call),
        .mispredict(mispredict), .restore_ghr(restore_ghr),
        .actual_taken(actual_taken), .actual_target_address(actual_target_address),
        .ghr_snap(ghr_snap), .rb_pht_index(rb_pht_index),
        .update_pht(update_pht), .update_btb(update_btb), .update_ras(update_ras),
        .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_ret(ex_is_ret),
        .actual_return_address(actual_return_address)
    );

    always #5 CLK = ~CLK;

    // Reference: in-flight records kept in program order.
    typedef struct {
        int          tag;
        bit          pt;
        logic [31:0] ptgt;
        logic [8:0]  pht;
        logic [8:0]  ghr;
        bit          resolved;
    } rec_t;

    rec_t q[$];
    int   next_tag;
    int   checks = 0;
    int   errors = 0;

    logic        e_mp, e_pht, e_btb, e_ras, e_taken, e_isb, e_isr;
    logic [31:0] e_tgt, e_pc, e_rar;
    logic [8:0]  e_ghr, e_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        q.delete();
        next_tag = 0;
        e_mp = 0; e_pht = 0; e_btb = 0; e_ras = 0; e_taken = 0; e_isb = 0; e_isr = 0;
        e_tgt = 0; e_pc = 0; e_rar = 0; e_ghr = 0; e_idx = 0;
    endtask

    // One clock: check combinational handshake, advance model and DUT, check registered outputs.
    task automatic cyc();
        int j;
        bit hit, mp, pop, fire, ready;
        j = -1; mp = 0;
        if (!reset && res_valid)
            foreach (q[k]) if (q[k].tag == int'(res_tag) && !q[k].resolved) j = k;
        hit = (j >= 0);
        if (hit) mp = (res_taken != q[j].pt) || (res_taken && res_target != q[j].ptgt);
        pop   = (q.size() > 0) && q[0].resolved;
        ready = !reset && (q.size() < DEPTH) && !mp && !e_mp;
        #1;
        chk("enq_ready", enq_ready, ready);
        if (!reset) chk("enq_tag", enq_tag, next_tag);
        fire = enq_valid && ready;
        @(posedge CLK);
        #1;
        if (reset) begin
            model_zero();
        end else begin
            e_mp = 0; e_pht = 0; e_btb = 0; e_ras = 0;
            if (hit) begin
                e_mp = mp; e_pht = res_is_branch; e_btb = res_taken; e_ras = res_is_call;
                e_taken = res_taken;
                e_tgt = res_taken ? res_target : res_pc + 32'd4;
                e_ghr = q[j].ghr; e_idx = q[j].pht;
                e_pc = res_pc; e_isb = res_is_branch; e_isr = res_is_ret;
                if (res_is_call) e_rar = res_pc + 32'd4;
                q[j].resolved = 1;
                if (mp) begin
                    while (q.size() > j + 1) void'(q.pop_back());
                    next_tag = (int'(res_tag) + 1) % DEPTH;
                end
            end
            if (pop) void'(q.pop_front());
            if (fire) begin
                q.push_back('{next_tag, enq_pred_taken, enq_pred_target, enq_pht_index, enq_ghr_snap, 1'b0});
                next_tag = (next_tag + 1) % DEPTH;
            end
        end
        chk("mispredict", mispredict, e_mp);
        chk("restore_ghr", restore_ghr, e_mp);
        chk("actual_taken", actual_taken, e_taken);
        chk("actual_target", actual_target_address, e_tgt);
        chk("ghr_snap", ghr_snap, e_ghr);
        chk("rb_pht_index", rb_pht_index, e_idx);
        chk("update_pht", update_pht, e_pht);
        chk("update_btb", update_btb, e_btb);
        chk("update_ras", update_ras, e_ras);
        chk("ex_pc", ex_pc, e_pc);
        chk("ex_is_branch", ex_is_branch, e_isb);
        chk("ex_is_ret", ex_is_ret, e_isr);
        chk("return_addr", actual_return_address, e_rar);
        chk("count", dut.count, q.size());
    endtask

    task automatic idle();
        enq_valid = 0; enq_pred_taken = 0; enq_pred_target = 0; enq_pht_index = 0; enq_ghr_snap = 0;
        res_valid = 0; res_tag = 0; res_pc = 0; res_taken = 0; res_target = 0;
        res_is_branch = 0; res_is_ret = 0; res_is_call = 0;
    endtask

    task automatic set_enq(input bit pt, input logic [31:0] tgt, input logic [8:0] pht, input logic [8:0] ghr);
        enq_valid = 1; enq_pred_taken = pt; enq_pred_target = tgt; enq_pht_index = pht; enq_ghr_snap = ghr;
    endtask

    task automatic set_res(input logic [2:0] tag, input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                           input bit isb, input bit isr, input bit isc);
        res_valid = 1; res_tag = tag; res_pc = pc; res_taken = tk; res_target = tgt;
        res_is_branch = isb; res_is_ret = isr; res_is_call = isc;
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        cyc();
        cyc();
        reset = 0;
    endtask

    initial begin
        model_zero();
        reset = 1;
        idle();
        // Reset: enq_ready low while reset is asserted, all registered outputs zero.
        cyc();
        cyc();
        chk("rst_mispredict", mispredict, 1'b0);
        chk("rst_target", actual_target_address, 32'h0);
        reset = 0;

        // Fill all 8 slots, no resolutions.
        for (int i = 0; i < 8; i++) begin
            set_enq(0, 32'h0, 9'(i * 3 + 7), 9'(i * 5 + 1));
            #1 chk("t1_tag", enq_tag, i);
            cyc();
        end
        idle();
        #1 chk("t1_full_ready", enq_ready, 1'b0);
        chk("t1_full_count", dut.count, 8);

        // tag0 predicted NT, actually taken to 0x100.
        set_res(3'd0, 32'h20, 1, 32'h100, 1, 0, 0);
        cyc();
        idle();
        chk("t2_mispredict", mispredict, 1'b1);
        chk("t2_target", actual_target_address, 32'h100);
        chk("t2_ghr", ghr_snap, 9'd1);
        chk("t2_pht", rb_pht_index, 9'd7);
        chk("t2_btb", update_btb, 1'b1);
        chk("t2_tail", dut.tail, 3'd1);
        cyc();
        chk("t2_pulse_end", mispredict, 1'b0);
        cyc();

        // Flush younger than tag 2, then a stale tag 3 must be ignored.
        do_reset();
        for (int i = 0; i < 4; i++) begin set_enq(0, 32'h0, 9'(i), 9'(i)); cyc(); end
        idle();
        set_res(3'd2, 32'h30, 1, 32'h200, 1, 0, 0);
        cyc();
        chk("t3_tail", dut.tail, 3'd3);
        chk("t3_count", dut.count, 3);
        set_res(3'd3, 32'h34, 1, 32'h300, 1, 0, 1);
        cyc();
        chk("t3_stale_pht", update_pht, 1'b0);
        chk("t3_stale_mp", mispredict, 1'b0);
        idle();
        cyc();

        // Out-of-order correct resolutions; head moves only once tag0 resolves.
        do_reset();
        for (int i = 0; i < 3; i++) begin set_enq(0, 32'h0, 9'(i), 9'(i)); cyc(); end
        idle();
        for (int t = 2; t >= 0; t--) begin
            set_res(3'(t), 32'h100 + 32'(t * 4), 0, 32'h0, 1, 0, 0);
            cyc();
            chk("t4_no_mp", mispredict, 1'b0);
            chk("t4_head_wait", dut.head, 3'd0);
        end
        idle();
        for (int h = 1; h <= 3; h++) begin
            cyc();
            chk("t4_head", dut.head, h);
        end

        // Correctly predicted call.
        set_enq(1, 32'h80, 9'h11, 9'h22);
        cyc();
        idle();
        set_res(3'd3, 32'h40, 1, 32'h80, 0, 0, 1);
        cyc();
        idle();
        chk("t5_ras", update_ras, 1'b1);
        chk("t5_ret_addr", actual_return_address, 32'h44);
        chk("t5_mp", mispredict, 1'b0);
        cyc();

        // Wrap: 20 enqueue/resolve pairs.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_enq(0, 32'h0, 9'(i), 9'(i));
            #1 chk("t6_tag", enq_tag, i % 8);
            cyc();
            idle();
            set_res(3'(i % 8), 32'h1000 + 32'(i * 4), 0, 32'h0, 1, 0, 0);
            cyc();
            idle();
            chk("t6_cnt_le8", dut.count <= 4'd8, 1'b1);
        end

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            idle();
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 1) == 1)
                set_enq(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h200,
                        9'($urandom), 9'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                set_res(3'($urandom_range(0, 7)),
                        ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00} >> 2 << 2,
                        1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h200,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    res_tag = 3'(q[$urandom_range(0, q.size() - 1)].tag);
            end
            cyc();
        end
        reset = 0;
        idle();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
